// File: rtl/uart_msg_reader_if.sv
// uart_msg_reader_if: command, block-memory read port and byte-stream signals of uart_msg_reader
interface uart_msg_reader_if #(
  parameter int AW = 5
);
  logic start;
  logic [AW-1:0] start_addr;
  logic [15:0] byte_count;
  logic busy;
  logic done;
  logic mem_read_en;
  logic [AW-1:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic out_valid;
  logic out_ready;
  logic [7:0] out_data;
  modport master (
    output start, start_addr, byte_count, mem_rdata, out_ready,
    input busy, done, mem_read_en, mem_raddr, out_valid, out_data
  );
  modport slave (
    input start, start_addr, byte_count, mem_rdata, out_ready,
    output busy, done, mem_read_en, mem_raddr, out_valid, out_data
  );
endinterface

// File: rtl/uart_msg_reader.sv
// uart_msg_reader: walks block-memory words and streams their bytes LSB first on valid/ready
// Define UART_MSG_READER_PREFETCH_EN to overlap the next word read with byte output.
module uart_msg_reader #(
  parameter int WORD_COUNT = 32,
  localparam int AW = $clog2(WORD_COUNT)
) (
  input logic clk,
  input logic rst_n,
  uart_msg_reader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SEND, FINISH} state_t;
`ifdef UART_MSG_READER_PREFETCH_EN
  localparam state_t WRAP_STATE = SEND;
  logic [31:0] r_hold;
  logic r_pf_data;
`else
  localparam state_t WRAP_STATE = FETCH;
`endif
  state_t r_state, w_next;
  logic [AW-1:0] r_addr, r_raddr, w_rd_addr;
  logic [15:0] r_remain;
  logic [1:0] r_idx;
  logic [31:0] r_word;
  logic r_rd_en, w_hs, w_last, w_wrap, w_issue;
  always_comb begin
    w_hs = r_state == SEND && bus.out_ready;
    w_last = r_remain == 16'd1;
    w_wrap = r_idx == 2'd3;
    w_rd_addr = r_state == IDLE ? bus.start_addr : r_addr;
    w_next = r_state;
    case (r_state)
      IDLE: w_next = !bus.start ? IDLE : bus.byte_count == 16'd0 ? FINISH : FETCH;
      FETCH: w_next = WAIT;
      WAIT: w_next = SEND;
      SEND: w_next = !w_hs ? SEND : w_last ? FINISH : w_wrap ? WRAP_STATE : SEND;
      default: w_next = IDLE;
    endcase
`ifdef UART_MSG_READER_PREFETCH_EN
    // read the following word on the first SEND cycle of each word that is not the last
    w_issue = w_next == FETCH || (r_state == WAIT && r_remain > 16'd4) ||
              (w_hs && w_wrap && r_remain > 16'd5);
`else
    w_issue = w_next == FETCH;
`endif
  end
  assign bus.busy = r_state inside {FETCH, WAIT, SEND};
  assign bus.done = r_state == FINISH;
  assign bus.out_valid = r_state == SEND;
  assign bus.out_data = r_state == SEND ? r_word[{r_idx, 3'b000} +: 8] : 8'd0;
  assign bus.mem_read_en = r_rd_en;
  assign bus.mem_raddr = r_raddr;
  always_ff @(posedge clk) r_state <= !rst_n ? IDLE : w_next;
  // r_addr always points at the next word still to be read
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_addr <= '0;
      r_raddr <= '0;
      r_rd_en <= 1'b0;
      r_remain <= '0;
      r_idx <= '0;
      r_word <= '0;
    end else begin
      r_rd_en <= w_issue;
      if (w_issue) begin
        r_raddr <= w_rd_addr;
        r_addr <= w_rd_addr == AW'(WORD_COUNT - 1) ? '0 : w_rd_addr + AW'(1);
      end
      if (r_state == IDLE && bus.start) r_remain <= bus.byte_count;
      if (r_state == WAIT) begin
        r_word <= bus.mem_rdata;
        r_idx <= '0;
      end
      if (w_hs) begin
        r_remain <= r_remain - 16'd1;
        r_idx <= r_idx + 2'd1;
      end
`ifdef UART_MSG_READER_PREFETCH_EN
      if (w_hs && w_wrap) r_word <= r_hold;
`endif
    end
`ifdef UART_MSG_READER_PREFETCH_EN
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_pf_data <= 1'b0;
      r_hold <= '0;
    end else begin
      r_pf_data <= r_rd_en && r_state == SEND;
      if (r_pf_data) r_hold <= bus.mem_rdata;
    end
`endif
endmodule

// File: tb/tb_uart_msg_reader.sv
// tb_uart_msg_reader: randomized scenarios checked against a byte-level model of the message stream
module tb_uart_msg_reader;
  localparam int WC = 32;
  localparam int AW = 5;
`ifdef UART_MSG_READER_PREFETCH_EN
  localparam int GAP = 0;
`else
  localparam int GAP = 2;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  uart_msg_reader_if #(.AW(AW)) bus();
  uart_msg_reader #(.WORD_COUNT(WC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [31:0] mem [WC];
  always @(posedge clk) if (bus.mem_read_en) bus.mem_rdata <= mem[bus.mem_raddr];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int errors = 0, checks = 0;
  logic [7:0] got_b[$];
  int got_c[$], got_a[$], done_q[$];
  int valid_n = 0, stall_err = 0, consec_err = 0;
  logic prev_v = 1'b0, prev_r = 1'b0, prev_rd = 1'b0;
  logic [7:0] prev_d = 8'd0;
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      got_b.push_back(bus.out_data);
      got_c.push_back(cyc);
    end
    if (bus.mem_read_en) got_a.push_back(int'(bus.mem_raddr));
    if (bus.mem_read_en && prev_rd) consec_err++;
    if (bus.done) done_q.push_back(cyc);
    if (bus.out_valid) valid_n++;
    if (prev_v && !prev_r && (!bus.out_valid || bus.out_data !== prev_d)) stall_err++;
    prev_v = bus.out_valid;
    prev_r = bus.out_ready;
    prev_d = bus.out_data;
    prev_rd = bus.mem_read_en;
  end
  function automatic logic [7:0] ref_byte(int addr, int i);
    logic [31:0] w;
    w = mem[(addr + i / 4) % WC];
    return w[8 * (i % 4) +: 8];
  endfunction
  function automatic int stream_errs(int addr, int cnt);
    int n = (got_b.size() == cnt) ? 0 : 1;
    for (int i = 0; i < cnt && i < got_b.size(); i++) if (got_b[i] !== ref_byte(addr, i)) n++;
    return n;
  endfunction
  function automatic int addr_errs(int addr, int cnt);
    int nw = (cnt + 3) / 4;
    int n = (got_a.size() == nw) ? 0 : 1;
    for (int k = 0; k < nw && k < got_a.size(); k++) if (got_a[k] != (addr + k) % WC) n++;
    return n;
  endfunction
  function automatic int timing_errs(int e0, int cnt);
    int n = (got_c.size() == cnt) ? 0 : 1;
    for (int i = 0; i < cnt && i < got_c.size(); i++) if (got_c[i] != e0 + 2 + i + GAP * (i / 4)) n++;
    return n;
  endfunction
  task automatic clear_mon();
    got_b.delete();
    got_c.delete();
    got_a.delete();
    done_q.delete();
    valid_n = 0;
    stall_err = 0;
    consec_err = 0;
  endtask
  task automatic run_msg(input int addr, input int cnt, input int pct, input int lo, input int hi,
                         input int inj, output int e0);
    int rel;
    clear_mon();
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.start_addr = AW'(addr);
    bus.byte_count = 16'(cnt);
    bus.out_ready = 1'b1;
    e0 = cyc + 1;
    for (int t = 0; t < 40 * cnt + 40 && done_q.size() == 0; t++) begin
      @(posedge clk); #1;
      rel = cyc - e0;
      bus.start = rel == inj;
      if (rel == inj) begin
        bus.start_addr = AW'(5);
        bus.byte_count = 16'd3;
      end
      bus.out_ready = (rel >= lo && rel <= hi) ? 1'b0 : int'($urandom_range(99)) < pct;
    end
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    logic [3:0] ctl;
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.byte_count = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    ctl = {bus.busy, bus.done, bus.mem_read_en, bus.out_valid};
    checks++; if (ctl !== 4'd0) begin errors++; $display("FAIL reset_ctl: got %b want 0000", ctl); end
    checks++; if ({bus.mem_raddr, bus.out_data} !== '0) begin
      errors++; $display("FAIL reset_data: raddr=%0h data=%0h want 0 0", bus.mem_raddr, bus.out_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask
  task automatic test_basic();
    int e0, n;
    mem[0] = 32'h64636261;
    mem[1] = 32'h00006665;
    run_msg(0, 6, 100, -1, -1, -1, e0);
    n = stream_errs(0, 6);
    checks++; if (n !== 0) begin errors++; $display("FAIL basic_bytes: bad=%0d want 0", n); end
    n = got_b.size() == 6 ? int'(got_b[5]) : -1;
    checks++; if (n !== 'h66) begin errors++; $display("FAIL basic_last: got %0h want 66", n); end
    n = timing_errs(e0, 6);
    checks++; if (n !== 0) begin errors++; $display("FAIL basic_timing: bad=%0d want 0", n); end
    n = got_c.size() > 4 ? got_c[4] - got_c[3] - 1 : -1;
    checks++; if (n !== GAP) begin errors++; $display("FAIL basic_bubble: got %0d want %0d", n, GAP); end
    checks++; if (got_a.size() !== 2) begin
      errors++; $display("FAIL basic_reads: got %0d want 2", got_a.size());
    end
    n = addr_errs(0, 6);
    checks++; if (n !== 0) begin errors++; $display("FAIL basic_addr: bad=%0d want 0", n); end
    n = done_q.size() == 1 ? done_q[0] - e0 : -1;
    checks++; if (n !== 8 + GAP) begin errors++; $display("FAIL basic_done: got %0d want %0d", n, 8 + GAP); end
    checks++; if (consec_err !== 0) begin errors++; $display("FAIL basic_consec: got %0d want 0", consec_err); end
  endtask
  task automatic test_zero();
    int e0, n;
    run_msg(4, 0, 100, -1, -1, -1, e0);
    n = done_q.size() == 1 ? done_q[0] - e0 : -1;
    checks++; if (n !== 0) begin errors++; $display("FAIL zero_done: got %0d want 0", n); end
    checks++; if (got_a.size() !== 0) begin errors++; $display("FAIL zero_reads: got %0d want 0", got_a.size()); end
    checks++; if (valid_n !== 0) begin errors++; $display("FAIL zero_valid: got %0d want 0", valid_n); end
  endtask
  task automatic test_wrap();
    int e0, n;
    mem[31] = $urandom;
    mem[0] = $urandom;
    run_msg(31, 8, 100, -1, -1, -1, e0);
    n = addr_errs(31, 8);
    checks++; if (n !== 0) begin errors++; $display("FAIL wrap_addr: bad=%0d want 0", n); end
    n = stream_errs(31, 8);
    checks++; if (n !== 0) begin errors++; $display("FAIL wrap_bytes: bad=%0d want 0", n); end
    n = timing_errs(e0, 8);
    checks++; if (n !== 0) begin errors++; $display("FAIL wrap_timing: bad=%0d want 0", n); end
  endtask
  task automatic test_backpressure();
    int e0, n;
    mem[0] = 32'h64636261;
    mem[1] = 32'h00006665;
    run_msg(0, 6, 100, 3, 7, -1, e0);
    checks++; if (stall_err !== 0) begin errors++; $display("FAIL bp_stable: got %0d want 0", stall_err); end
    n = stream_errs(0, 6);
    checks++; if (n !== 0) begin errors++; $display("FAIL bp_bytes: bad=%0d want 0", n); end
    n = got_c.size() > 1 ? got_c[1] - e0 : -1;
    checks++; if (n !== 8) begin errors++; $display("FAIL bp_accept: got %0d want 8", n); end
    checks++; if (valid_n !== 11) begin errors++; $display("FAIL bp_valid: got %0d want 11", valid_n); end
    checks++; if (got_a.size() !== 2) begin errors++; $display("FAIL bp_reads: got %0d want 2", got_a.size()); end
  endtask
  task automatic test_ignore_start();
    int e0, n;
    for (int k = 0; k < WC; k++) mem[k] = $urandom;
    run_msg(10, 11, 100, -1, -1, 4, e0);
    n = stream_errs(10, 11);
    checks++; if (n !== 0) begin errors++; $display("FAIL ign_bytes: bad=%0d want 0", n); end
    n = addr_errs(10, 11);
    checks++; if (n !== 0) begin errors++; $display("FAIL ign_addr: bad=%0d want 0", n); end
    n = timing_errs(e0, 11);
    checks++; if (n !== 0) begin errors++; $display("FAIL ign_timing: bad=%0d want 0", n); end
    checks++; if (done_q.size() !== 1) begin errors++; $display("FAIL ign_done: got %0d want 1", done_q.size()); end
  endtask
  task automatic test_done_start();
    int e0, n;
    clear_mon();
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.start_addr = '0;
    bus.byte_count = 16'd4;
    bus.out_ready = 1'b1;
    e0 = cyc + 1;
    while (cyc < e0 + 6) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    bus.start = 1'b1;
    bus.start_addr = AW'(7);
    bus.byte_count = 16'd1;
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n = done_q.size() == 2 ? (done_q[0] - e0) * 100 + (done_q[1] - e0) : -1;
    checks++; if (n !== 611) begin errors++; $display("FAIL ds_done: got %0d want 611", n); end
    n = got_a.size() == 2 ? got_a[0] * 100 + got_a[1] : -1;
    checks++; if (n !== 7) begin errors++; $display("FAIL ds_addr: got %0d want 7", n); end
    n = got_b.size() == 5 ? 0 : 1;
    for (int i = 0; i < 5 && i < got_b.size(); i++) if (got_b[i] !== (i < 4 ? ref_byte(0, i) : ref_byte(7, 0))) n++;
    checks++; if (n !== 0) begin errors++; $display("FAIL ds_bytes: bad=%0d want 0", n); end
  endtask
  task automatic test_reset_mid();
    int e0, n;
    logic [3:0] ctl;
    clear_mon();
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.start_addr = AW'(3);
    bus.byte_count = 16'd10;
    bus.out_ready = 1'b1;
    e0 = cyc + 1;
    while (cyc < e0 + 5) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    ctl = {bus.busy, bus.done, bus.mem_read_en, bus.out_valid};
    checks++; if (ctl !== 4'd0) begin errors++; $display("FAIL rmid_ctl: got %b want 0000", ctl); end
    checks++; if ({bus.mem_raddr, bus.out_data} !== '0) begin
      errors++; $display("FAIL rmid_data: raddr=%0h data=%0h want 0 0", bus.mem_raddr, bus.out_data);
    end
    checks++; if (done_q.size() !== 0) begin errors++; $display("FAIL rmid_nodone: got %0d want 0", done_q.size()); end
    run_msg(20, 7, 70, -1, -1, -1, e0);
    n = stream_errs(20, 7);
    checks++; if (n !== 0) begin errors++; $display("FAIL rmid_bytes: bad=%0d want 0", n); end
    n = addr_errs(20, 7);
    checks++; if (n !== 0) begin errors++; $display("FAIL rmid_addr: bad=%0d want 0", n); end
    checks++; if (done_q.size() !== 1) begin errors++; $display("FAIL rmid_done: got %0d want 1", done_q.size()); end
  endtask
  task automatic test_random_back_to_back();
    int e0, n, a, c, p;
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < WC; k++) mem[k] = $urandom;
      a = int'($urandom_range(31));
      c = int'($urandom_range(24, 1));
      p = int'($urandom_range(100, 30));
      run_msg(a, c, p, -1, -1, -1, e0);
      n = stream_errs(a, c);
      checks++; if (n !== 0) begin errors++; $display("FAIL rnd_bytes: it=%0d bad=%0d want 0", it, n); end
      n = addr_errs(a, c);
      checks++; if (n !== 0) begin errors++; $display("FAIL rnd_addr: it=%0d bad=%0d want 0", it, n); end
      checks++; if (done_q.size() !== 1) begin
        errors++; $display("FAIL rnd_done: it=%0d got %0d want 1", it, done_q.size());
      end
      checks++; if (stall_err + consec_err !== 0) begin
        errors++; $display("FAIL rnd_stable: it=%0d got %0d want 0", it, stall_err + consec_err);
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_wrap();
    test_backpressure();
    test_ignore_start();
    test_done_start();
    test_reset_mid();
    test_random_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_msg_reader.md
# uart_msg_reader

Message-fetch stage sitting directly downstream of the 32-bit block memory and upstream of the UART transmitter. On a start command it walks a run of words in the block memory through that memory's one-cycle registered read port. It unpacks each word into bytes, least-significant byte first, and presents them on a valid/ready byte stream for the transmitter. It signals completion with a one-cycle done pulse.

## Interface
- WORD_COUNT, 32, depth of the attached block memory; address width AW = $clog2(WORD_COUNT)
- clk  input  1  rising-edge clock for all state
- rst_n  input  1  synchronous, active-low reset; sampled on rising clk
- start  input  1  begin a message; accepted only when busy=0
- start_addr  input  AW  first word address, sampled with start
- byte_count  input  16  message length in bytes, sampled with start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when the message has completed
- mem_read_en  output  1  read strobe to block memory (registered)
- mem_raddr  output  AW  read address to block memory (registered)
- mem_rdata  input  32  read data; valid the cycle after the memory's read edge
- out_valid  output  1  out_data holds a byte
- out_ready  input  1  transmitter accepts the byte this cycle
- out_data  output  8  byte to transmit

## Operation
- States: IDLE, FETCH, WAIT, SEND, FINISH.
- IDLE: start=1 latches start_addr and byte_count and sets busy.
  - byte_count=0 goes to FINISH with no memory read.
  - Otherwise goes to FETCH.
- FETCH: mem_read_en=1 and mem_raddr=current address for exactly one cycle, then WAIT.
- WAIT: mem_rdata is captured into the word register, the byte index is cleared, then SEND.
- SEND: out_valid=1 and out_data=word[8*idx+7:8*idx]. Each handshake (out_valid & out_ready) decrements the remaining count and increments idx.
  - Remaining count reaches 0: go to FINISH.
  - idx wraps from 3 to 0: address increments and the state goes to FETCH.
- FINISH: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- Word address increments modulo WORD_COUNT; WORD_COUNT-1 wraps to 0.
- The last word emits only byte_count mod 4 bytes, or 4 bytes if that value is 0. Its unused upper bytes are never presented.
- out_data and out_valid stay stable while out_valid=1 and out_ready=0.
- out_ready is ignored while out_valid=0.
- start while busy=1 is ignored; latched parameters are not disturbed.
- Reset at any time, including mid-message, returns to IDLE on the next edge.
  - Values after reset: busy=0, done=0, mem_read_en=0, mem_raddr=0, out_valid=0, out_data=0, word register cleared.

## Timing
- Let E0 be the edge at which start is accepted.
- After E0: mem_read_en=1.
- After E1: WAIT.
- After E2: out_valid=1 with byte 0. First-byte latency is 3 edges.
- Without prefetch, a word boundary costs 2 idle cycles (FETCH, WAIT) between the handshake of byte 3 and out_valid for the next byte 0.
- done rises on the edge after the final handshake and lasts one cycle.
- A start presented during the done cycle is ignored.
- A start may be accepted on the following cycle.
- mem_read_en is never high for more than one consecutive cycle per word.

## Configuration
- UART_MSG_READER_PREFETCH_EN.
- Defined:
  - A one-word holding register is added.
  - The next word's read is issued in the first SEND cycle of the current word, if more words remain.
  - Its data is captured into the holding register two cycles later.
  - On the byte-3 handshake the holding register moves into the word register and SEND continues.
  - With out_ready held high, out_valid stays continuously high for the whole message.
  - First-byte latency is unchanged.
- Undefined: no holding register; the 2-cycle word-boundary bubble applies.

## Test plan
- Memory words 0x64636261 and 0x00006665 at addr 0 and 1; start addr=0, count=6, out_ready=1.
  - Expected bytes: 61 62 63 64 65 66.
  - Expected bubble: 2 cycles before 65 without prefetch, none with prefetch.
  - done pulses 1 cycle after 66; exactly 2 mem_read_en pulses.
- count=0: done pulses on the edge after start; no mem_read_en; out_valid never rises.
- WORD_COUNT=32, addr=31, count=8.
  - Expected raddr sequence: 31 then 0.
  - Expected bytes: word31 bytes then word0 bytes.
- Backpressure: out_ready low for 5 cycles while byte 0x62 is presented.
  - out_data stays 0x62 and out_valid stays 1 throughout.
  - No extra read is issued without prefetch.
- start pulsed again mid-message with addr=5: ignored; the original byte stream completes unchanged.
- rst_n low for 1 cycle after the 3rd byte handshake.
  - All outputs are 0 on the next cycle, state is IDLE.
  - A fresh start works normally.
